// File: rtl/operand_loader_pkg.sv
// Shared types for the operand loader: load sequencing states and their encoding width.
package operand_loader_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        READY  = 2'b10
    } load_state_t;

    // Operand register written by a press taken in state s.
    function automatic logic press_targets_a(input load_state_t s);
        return (s == LOAD_A) || (s == READY);
    endfunction

endpackage

// File: rtl/operand_loader_button_debouncer.sv
// Button conditioning for the operand loader: 2-flop synchronizer, consecutive-sample
// debounce counter and a registered rising-edge strobe on the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    assign btn_sync = sync_q[1];

    // A sample that agrees with the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            rise_q <= 1'b0;
            if (btn_sync == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= btn_sync;
                rise_q  <= btn_sync;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;

endmodule

// File: rtl/operand_loader.sv
// Operand loader: debounced push-button steps A/B operand capture for the ALU.
// Optional press counter output enabled by defining OPERAND_LOADER_PRESS_COUNT_EN.
//
// state  | meaning
// LOAD_A | waiting for a press to capture operand A
// LOAD_B | waiting for a press to capture operand B
// READY  | both operands held; next press recaptures A
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_load,
    input  logic [DATA_W-1:0]  input_bits,
    output logic [DATA_W-1:0]  a_val,
    output logic [DATA_W-1:0]  b_val,
    output logic [STATE_W-1:0] load_state,
    output logic               operands_valid,
    output logic               load_pulse
`ifdef OPERAND_LOADER_PRESS_COUNT_EN
    ,
    output logic [7:0]         press_count
`endif
);

    logic        btn_level;
    logic        btn_rise;
    logic        press;
    logic        cap_a;
    logic        cap_b;
    load_state_t state;
    load_state_t state_next;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_load),
        .btn_level(btn_level),
        .btn_rise (btn_rise)
    );

    assign press = btn_rise & btn_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state)
            LOAD_A, READY: begin
                if (press) begin
                    cap_a      = press_targets_a(state);
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    cap_b      = 1'b1;
                    state_next = READY;
                end
            end
            default: state_next = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_val      <= '0;
            b_val      <= '0;
            load_pulse <= 1'b0;
        end else begin
            if (cap_a) begin
                a_val <= input_bits;
            end
            if (cap_b) begin
                b_val <= input_bits;
            end
            load_pulse <= cap_a | cap_b;
        end
    end

`ifdef OPERAND_LOADER_PRESS_COUNT_EN
    logic [7:0] press_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            press_cnt_q <= 8'd0;
        end else if (cap_a | cap_b) begin
            press_cnt_q <= press_cnt_q + 8'd1;
        end
    end

    assign press_count = press_cnt_q;
`endif

    assign load_state     = state;
    assign operands_valid = (state == READY);

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a window-based button model predicts each capture,
// pushes it to a queue, and a negedge monitor pops and compares on every load_pulse.
module tb_operand_loader;

    localparam int D    = 4;
    localparam int W    = 8;
    localparam int MAXE = 30000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         btn_load = 1'b0;
    logic [W-1:0] input_bits = '0;
    logic [W-1:0] a_val;
    logic [W-1:0] b_val;
    logic [1:0]   load_state;
    logic         operands_valid;
    logic         load_pulse;
`ifdef OPERAND_LOADER_PRESS_COUNT_EN
    logic [7:0]   press_count;
`endif

    operand_loader #(
        .DEBOUNCE_CYCLES(D),
        .DATA_W         (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_load      (btn_load),
        .input_bits    (input_bits),
        .a_val         (a_val),
        .b_val         (b_val),
        .load_state    (load_state),
        .operands_valid(operands_valid),
        .load_pulse    (load_pulse)
`ifdef OPERAND_LOADER_PRESS_COUNT_EN
        ,
        .press_count   (press_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] st;
        logic       v;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int pulses = 0;
    int last_reset = 0;
    bit raw_hist [MAXE];

    logic       m_level = 1'b0;
    bit         m_pend = 1'b0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic [1:0] m_st = 2'd0;
    logic [7:0] m_pc = 8'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, want, edge_n);
        end
    endfunction

    // Reference model: the debounced level flips once the D most recent synchronized
    // samples (raw delayed by two edges, zero across a reset) all disagree with it.
    initial begin : model
        bit flip;
        bit r;
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            if (edge_n >= MAXE) begin
                $display("FAIL edge_budget: got %0d expected below %0d", edge_n, MAXE);
                $fatal(1);
            end
            raw_hist[edge_n] = btn_load;
            if (reset) begin
                last_reset = edge_n;
                m_level = 1'b0;
                m_pend  = 1'b0;
                m_a = 8'd0; m_b = 8'd0; m_st = 2'd0; m_pc = 8'd0;
            end else begin
                if (m_pend) begin
                    case (m_st)
                        2'd0:    begin m_a = input_bits; m_st = 2'd1; end
                        2'd1:    begin m_b = input_bits; m_st = 2'd2; end
                        default: begin m_a = input_bits; m_st = 2'd1; end
                    endcase
                    m_pc = m_pc + 8'd1;
                    e.cyc = edge_n; e.a = m_a; e.b = m_b; e.st = m_st;
                    e.v = (m_st == 2'd2); e.pc = m_pc;
                    sb.push_back(e);
                end
                m_pend = 1'b0;
                flip = (edge_n - 1 - D >= 1);
                for (int x = edge_n - 1 - D; x <= edge_n - 2; x++) begin
                    if (x >= 1) begin
                        r = (x <= last_reset) ? 1'b0 : raw_hist[x];
                        if (r == m_level) flip = 1'b0;
                    end
                end
                if (flip) begin
                    m_level = ~m_level;
                    if (m_level) m_pend = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (edge_n >= 1) begin
                if (load_pulse === 1'b1) begin
                    pulses++;
                    if (sb.size() == 0) begin
                        chk("pulse_unexpected", 32'(load_pulse), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_cycle", 32'(edge_n), 32'(mon_e.cyc));
                        chk("sb_a_val", 32'(a_val), 32'(mon_e.a));
                        chk("sb_b_val", 32'(b_val), 32'(mon_e.b));
                        chk("sb_state", 32'(load_state), 32'(mon_e.st));
                        chk("sb_valid", 32'(operands_valid), 32'(mon_e.v));
`ifdef OPERAND_LOADER_PRESS_COUNT_EN
                        chk("sb_press_count", 32'(press_count), 32'(mon_e.pc));
`endif
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= edge_n) begin
                    mon_e = sb.pop_front();
                    chk("pulse_missing", 32'(load_pulse), 32'd1);
                end
                chk("track_outputs", 32'({a_val, b_val, load_state, operands_valid}),
                    32'({m_a, m_b, m_st, (m_st == 2'd2)}));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step(input logic b, input logic [7:0] bits, input logic r);
        @(posedge clk);
        #1;
        btn_load   = b;
        input_bits = bits;
        reset      = r;
    endtask

    task automatic hold(input int n, input logic b, input logic [7:0] bits);
        repeat (n) step(b, bits, 1'b0);
    endtask

    task automatic press(input logic [7:0] bits);
        hold(D + 4, 1'b1, bits);
        hold(D + 4, 1'b0, bits);
    endtask

    initial begin : stim
        int p0;
        int n;
        int len;
        int acc;
        logic lvl;

        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_a_val", 32'(a_val), 32'd0);
        chk("rst_b_val", 32'(b_val), 32'd0);
        chk("rst_state", 32'(load_state), 32'd0);
        chk("rst_valid", 32'(operands_valid), 32'd0);
        chk("rst_pulse", 32'(load_pulse), 32'd0);

        // first press: capture lands exactly 7 edges after btn_load rises
        p0 = pulses;
        step(1'b1, 8'h3C, 1'b0);
        repeat (6) step(1'b1, 8'h3C, 1'b0);
        @(negedge clk);
        chk("lat_a_before", 32'(a_val), 32'd0);
        step(1'b1, 8'h3C, 1'b0);
        @(negedge clk);
        chk("lat_a_at7", 32'(a_val), 32'h3C);
        chk("lat_pulse_at7", 32'(load_pulse), 32'd1);
        chk("lat_state", 32'(load_state), 32'd1);
        step(1'b1, 8'h3C, 1'b0);
        @(negedge clk);
        chk("lat_pulse_after", 32'(load_pulse), 32'd0);
        hold(4, 1'b1, 8'h3C);
        hold(D + 4, 1'b0, 8'h00);
        chk("first_press_pulses", 32'(pulses - p0), 32'd1);

        press(8'hA5);
        @(negedge clk);
        chk("b_load_b_val", 32'(b_val), 32'hA5);
        chk("b_load_state", 32'(load_state), 32'd2);
        chk("b_load_valid", 32'(operands_valid), 32'd1);
        press(8'h11);
        @(negedge clk);
        chk("reload_a_val", 32'(a_val), 32'h11);
        chk("reload_b_val", 32'(b_val), 32'hA5);
        chk("reload_valid", 32'(operands_valid), 32'd0);
        chk("reload_state", 32'(load_state), 32'd1);

        // bounce bursts shorter than the debounce window
        p0 = pulses;
        n = 0;
        lvl = 1'b1;
        while (n < 40) begin
            len = $urandom_range(1, D - 1);
            hold(len, lvl, 8'($urandom));
            n += len;
            lvl = ~lvl;
        end
        hold(D + 6, 1'b0, 8'h00);
        @(negedge clk);
        chk("glitch_pulses", 32'(pulses - p0), 32'd0);
        chk("glitch_state", 32'(load_state), 32'd1);
        chk("glitch_a_val", 32'(a_val), 32'h11);
        chk("glitch_b_val", 32'(b_val), 32'hA5);

        p0 = pulses;
        hold(100, 1'b1, 8'h5A);
        hold(D + 4, 1'b0, 8'h00);
        @(negedge clk);
        chk("hold_pulses", 32'(pulses - p0), 32'd1);
        chk("hold_b_val", 32'(b_val), 32'h5A);

        // reset coincident with a press event while in LOAD_B
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        press(8'h21);
        step(1'b1, 8'h77, 1'b0);
        repeat (5) step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_press_a_val", 32'(a_val), 32'd0);
        chk("rst_press_b_val", 32'(b_val), 32'd0);
        chk("rst_press_state", 32'(load_state), 32'd0);
        chk("rst_press_pulse", 32'(load_pulse), 32'd0);
        hold(10, 1'b0, 8'h00);
        @(negedge clk);
        chk("rst_press_b_later", 32'(b_val), 32'd0);

        // reset mid-debounce with the button still held: one fresh press afterwards
        p0 = pulses;
        repeat (3) step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h44, 1'b1);
        step(1'b1, 8'h44, 1'b0);
        hold(12, 1'b1, 8'h44);
        hold(D + 4, 1'b0, 8'h00);
        @(negedge clk);
        chk("mid_rst_pulses", 32'(pulses - p0), 32'd1);
        chk("mid_rst_a_val", 32'(a_val), 32'h44);

        // random presses and sub-window glitches, 257 accepted presses after reset
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        acc = 0;
        while (acc < 257) begin
            len = $urandom_range(1, D + 5);
            for (int i = 0; i < len; i++) step(1'b1, 8'($urandom), 1'b0);
            if (len >= D) acc++;
            len = $urandom_range(D, D + 4);
            for (int i = 0; i < len; i++) step(1'b0, 8'($urandom), 1'b0);
        end
        hold(10, 1'b0, 8'h00);
        @(negedge clk);
`ifdef OPERAND_LOADER_PRESS_COUNT_EN
        chk("press_count_wrap", 32'(press_count), 32'd1);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
